// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: default width and direction encodings.
package counter_pkg;

    localparam int CNT_WIDTH = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/counter_bit.sv
// One state bit of the counter: D flip-flop with synchronous active-high reset.
module counter_bit #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rest,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rest) q <= RST_BIT;
        else      q <= d;
    end

endmodule

// File: rtl/counter.sv
// WIDTH-bit wrapping up/down counter; next state computed here, bits held in counter_bit.
module counter
    import counter_pkg::*;
#(
    parameter int               WIDTH     = CNT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             s,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] nxt;

    // WIDTH-bit arithmetic drops the carry/borrow, giving modulo wrap.
    always_comb begin
        nxt = q - ONE;
        if (s == DIR_UP) nxt = q + ONE;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        counter_bit #(
            .RST_BIT (RESET_VAL[i])
        ) u_bit (
            .clk  (clk),
            .rest (rest),
            .d    (nxt[i]),
            .q    (q[i])
        );
    end

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: default 4-bit instance plus a 3-bit RESET_VAL=5 instance.
module tb_counter;

    logic       clk = 1'b0;
    logic       rest;
    logic       s;
    logic [3:0] q;
    logic [2:0] q2;
    logic [2:0] m2;
    logic [3:0] ref_q;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    counter u_dut (
        .clk  (clk),
        .rest (rest),
        .s    (s),
        .q    (q)
    );

    counter #(
        .WIDTH     (3),
        .RESET_VAL (3'd5)
    ) u_dut2 (
        .clk  (clk),
        .rest (rest),
        .s    (s),
        .q    (q2)
    );

    task automatic check4(input logic [3:0] obs, input logic [3:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: q=%b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one edge, update the 3-bit model from the sampled inputs, check both DUTs.
    task automatic step(input logic [3:0] exp, input string tag);
        @(posedge clk);
        if (rest)   m2 = 3'd5;
        else if (s) m2 = m2 + 3'd1;
        else        m2 = m2 - 3'd1;
        #1;
        check4(q, exp, tag);
        n_cmp++;
        assert (q2 === m2) else begin
            n_err++;
            $error("FAIL %s_w3: q2=%b expected %b", tag, q2, m2);
        end
    endtask

    initial begin
        m2   = 3'd5;
        rest = 1'b1;
        s    = 1'b1;
        @(negedge clk);

        // Reset held two edges with either s value.
        step(4'b0000, "rst_s1");
        s = 1'b0;
        step(4'b0000, "rst_s0");
        rest = 1'b0;
        s    = 1'b1;
        step(4'b0001, "up1");
        step(4'b0010, "up2");
        step(4'b0011, "up3");

        // Up wrap over 20 edges from reset.
        rest = 1'b1;
        step(4'b0000, "rst_wrap");
        rest = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step(4'(i % 16), "upwrap");
        end
        check4(q, 4'b0100, "upwrap_end");

        // Down wrap from reset.
        rest = 1'b1;
        step(4'b0000, "rst_dn");
        rest = 1'b0;
        s    = 1'b0;
        step(4'b1111, "dn1");
        step(4'b1110, "dn2");
        step(4'b1101, "dn3");

        // Direction reversal at 5.
        rest = 1'b1;
        step(4'b0000, "rst_rev");
        rest = 1'b0;
        s    = 1'b1;
        repeat (4) step(q + 4'd1, "rev_up");
        step(4'b0101, "rev_at5");
        s = 1'b0;
        step(4'b0100, "rev_dn1");
        step(4'b0011, "rev_dn2");

        // Reset mid-count at 10, with s=1 still asserted (reset wins).
        rest = 1'b1;
        step(4'b0000, "rst_mid");
        rest = 1'b0;
        s    = 1'b1;
        repeat (9) step(q + 4'd1, "mid_up");
        step(4'b1010, "mid_at10");
        rest = 1'b1;
        step(4'b0000, "mid_rst");
        rest = 1'b0;
        step(4'b0001, "mid_resume1");
        step(4'b0010, "mid_resume2");

        // Glitches on s between edges: only the value at the edge counts.
        s = 1'b0;
        #1 s = 1'b1;
        #1 s = 1'b0;
        #1 s = 1'b1;
        step(4'b0011, "glitch_up");
        s = 1'b1;
        #2 s = 1'b0;
        step(4'b0010, "glitch_dn");

        // Long run: 100 edges up from reset against a reference counter.
        rest = 1'b1;
        step(4'b0000, "rst_long");
        rest  = 1'b0;
        s     = 1'b1;
        ref_q = 4'd0;
        for (int i = 0; i < 100; i++) begin
            ref_q = ref_q + 4'd1;
            step(ref_q, "long");
        end
        check4(q, 4'b0100, "long_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits.
REQ-002 Parameter: RESET_VAL, default 0, value loaded into q on reset.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rest  input  1  reset, synchronous, active-high.
REQ-005 Port: s  input  1  direction select; 1 = count up, 0 = count down.
REQ-006 Port: q  output  WIDTH  current count value, driven directly from a register.
REQ-007 The block SHALL use one clock; reset is synchronous and active-high.

Function
REQ-008 On each rising clk edge with rest=0 and s=1, q SHALL become q+1 modulo 2^WIDTH.
REQ-009 On each rising clk edge with rest=0 and s=0, q SHALL become q-1 modulo 2^WIDTH.
REQ-010 Up wrap: q=4'b1111 with s=1 SHALL become 4'b0000 on the next edge.
REQ-011 Down wrap: q=4'b0000 with s=0 SHALL become 4'b1111 on the next edge.
REQ-012 Latency SHALL be one cycle: a change on s affects only the update at the next rising edge after it is sampled.
REQ-013 s SHALL be sampled only at rising clk edges; glitches between edges SHALL have no effect.
REQ-014 q SHALL change only at rising clk edges, never combinationally from s or rest.
REQ-015 No count SHALL be skipped or repeated while rest=0; the sequence is strictly monotonic modulo 2^WIDTH in the selected direction.
REQ-016 Arithmetic SHALL be WIDTH bits unsigned; the carry or borrow out of the MSB SHALL be discarded.
REQ-017 A direction reversal SHALL take effect immediately: for example, q=5 with s switching from 1 to 0 yields 4 at the next edge.

Reset
REQ-018 When rest=1 at a rising clk edge, q SHALL become RESET_VAL (4'b0000 by default), regardless of s.
REQ-019 Reset SHALL take priority over counting on the same edge.
REQ-020 Asserting reset mid-count SHALL abort the count at the next edge, with no residual state.
REQ-021 After rest deasserts, the first count update SHALL occur at the first rising edge sampled with rest=0, starting from RESET_VAL.
REQ-022 Before the first reset, q is undefined; the bench SHALL apply reset before checking any value.

Structure
REQ-023 Shared package counter_pkg SHALL hold the WIDTH default and the direction encodings DIR_UP=1 and DIR_DOWN=0.
REQ-024 Each state bit SHALL be held in one sub-module, counter_bit, instantiated WIDTH times in a generate loop.
REQ-025 counter_bit SHALL be a D flip-flop with synchronous active-high reset to its RESET_VAL bit.
REQ-026 Next-state logic SHALL be computed in the top level.
REQ-027 The top level SHALL contain no latches and SHALL be fully synthesizable.

Verification
REQ-028 Reset: rest=1 for 2 cycles, any s -> q=0000; then rest=0, s=1 -> q=0001, 0010, 0011 on successive edges.
REQ-029 Up wrap: s=1 for 20 cycles from reset -> q reaches 1111 at cycle 15, then 0000 at cycle 16, then 0001.
REQ-030 Down wrap: from reset with s=0 -> q=1111, 1110, 1101 on the first three edges.
REQ-031 Direction change: count up to 0101, then set s=0 -> q=0100 next edge, 0011 after.
REQ-032 Mid-count reset: at q=1010, pulse rest=1 for one edge -> q=0000, then counting resumes from 0001 with s=1.
REQ-033 Long run: 100 cycles with s=1 from reset -> q = 100 mod 16 = 0100, checked every edge by a reference model.
